// File: rtl/pong_matrix_engine.sv
// Single-player Pong engine for a row/column-scanned LED matrix.
// Ball and paddle physics, serve/play/miss sequencing, 1 pixel/clk raster.
module pong_matrix_engine #(
  parameter int COLS       = 15,
  parameter int ROWS       = 10,
  parameter int PADDLE_LEN = 3,
  parameter int TICK_DIV   = 524288,
  parameter int PAD_DIV    = 262144,
  parameter int MISS_TICKS = 8
) (
  input  logic            p_clk12,
  input  logic            p_rst,
  input  logic            p_upBtn,
  input  logic            p_dwnBtn,
  output wire [COLS-1:0]  p_hLED,
  output wire [ROWS-1:0]  p_vLED,
  output logic [3:0]      p_misses,
  output logic [1:0]      p_state
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = $clog2(PAD_DIV);
  localparam int MW = $clog2(MISS_TICKS + 1);

  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [XW-1:0] X_MID = XW'(COLS / 2);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);
  localparam logic [YW-1:0] Y_MID = YW'(ROWS / 2);
  localparam logic [YW-1:0] PAD_MAX = YW'(ROWS - PADDLE_LEN);
  localparam logic [YW-1:0] PAD_RST =
    YW'((ROWS - PADDLE_LEN) / 2);
  localparam logic [YW:0] PAD_LEN = (YW+1)'(PADDLE_LEN);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PAD_LAST = PW'(PAD_DIV - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_TICKS - 1);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_PLAY  = 2'd1,
    S_MISS  = 2'd2
  } state_e;

  function automatic logic in_pad(
    input logic [YW-1:0] r,
    input logic [YW-1:0] top
  );
    return (r >= top) &&
           ({1'b0, r} < ({1'b0, top} + PAD_LEN));
  endfunction

  // Button synchronisers plus one extra stage for edge detect
  logic up_s1_q, up_s2_q, up_p_q;
  logic dn_s1_q, dn_s2_q, dn_p_q;
  logic serve_req;

  always_ff @(posedge p_clk12) begin
    if (p_rst) begin
      up_s1_q <= 1'b0;
      up_s2_q <= 1'b0;
      up_p_q  <= 1'b0;
      dn_s1_q <= 1'b0;
      dn_s2_q <= 1'b0;
      dn_p_q  <= 1'b0;
    end else begin
      up_s1_q <= p_upBtn;
      up_s2_q <= up_s1_q;
      up_p_q  <= up_s2_q;
      dn_s1_q <= p_dwnBtn;
      dn_s2_q <= dn_s1_q;
      dn_p_q  <= dn_s2_q;
    end
  end

  assign serve_req = (up_s2_q & ~up_p_q) |
                     (dn_s2_q & ~dn_p_q);

  logic [PW-1:0] pdiv_q, pdiv_d;
  logic [YW-1:0] pad_q, pad_d;

  always_comb begin
    pdiv_d = '0;
    pad_d  = pad_q;
    if (up_s2_q ^ dn_s2_q) begin
      if (pdiv_q == PAD_LAST) begin
        if (up_s2_q && pad_q != '0)
          pad_d = pad_q - 1'b1;
        else if (dn_s2_q && pad_q != PAD_MAX)
          pad_d = pad_q + 1'b1;
      end else begin
        pdiv_d = pdiv_q + 1'b1;
      end
    end
  end

  always_ff @(posedge p_clk12) begin
    if (p_rst) begin
      pdiv_q <= '0;
      pad_q  <= PAD_RST;
    end else begin
      pdiv_q <= pdiv_d;
      pad_q  <= pad_d;
    end
  end

  logic [TW-1:0] tdiv_q, tdiv_d;
  logic          tick;

  assign tick   = tdiv_q == TICK_LAST;
  assign tdiv_d = tick ? '0 : tdiv_q + 1'b1;

  always_ff @(posedge p_clk12) begin
    if (p_rst) tdiv_q <= '0;
    else       tdiv_q <= tdiv_d;
  end

  state_e        state_q;
  logic [XW-1:0] bx_q, nx;
  logic [YW-1:0] by_q, ny;
  logic          vx_neg_q, vy_neg_q;
  logic          vx_neg_t, vx_neg_d, vy_neg_d;
  logic          hit, miss;
  logic [3:0]    miss_q;
  logic [MW-1:0] mcnt_q;

  // Next ball step: wall flips, then paddle test on the new row
  always_comb begin
    vy_neg_d = vy_neg_q;
    if (by_q == '0 && vy_neg_q)
      vy_neg_d = 1'b0;
    else if (by_q == Y_MAX && !vy_neg_q)
      vy_neg_d = 1'b1;
    vx_neg_t = vx_neg_q | (bx_q == X_MAX);
    ny = vy_neg_d ? by_q - 1'b1 : by_q + 1'b1;
    hit = (bx_q == X_ONE) && vx_neg_t &&
          in_pad(ny, pad_q);
    vx_neg_d = vx_neg_t & ~hit;
    nx = vx_neg_d ? bx_q - 1'b1 : bx_q + 1'b1;
    miss = nx == '0;
  end

  always_ff @(posedge p_clk12) begin
    if (p_rst) begin
      state_q  <= S_SERVE;
      bx_q     <= X_MID;
      by_q     <= Y_MID;
      vx_neg_q <= 1'b0;
      vy_neg_q <= 1'b0;
      miss_q   <= '0;
      mcnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_SERVE: begin
          if (serve_req) state_q <= S_PLAY;
        end
        S_PLAY: begin
          if (tick) begin
            bx_q     <= nx;
            by_q     <= ny;
            vx_neg_q <= vx_neg_d;
            vy_neg_q <= vy_neg_d;
            if (miss) begin
              state_q <= S_MISS;
              mcnt_q  <= '0;
              if (miss_q != 4'hF)
                miss_q <= miss_q + 1'b1;
            end
          end
        end
        S_MISS: begin
          if (tick) begin
            if (mcnt_q == MISS_LAST) begin
              state_q  <= S_SERVE;
              bx_q     <= X_MID;
              by_q     <= Y_MID;
              vx_neg_q <= 1'b0;
              mcnt_q   <= '0;
            end else begin
              mcnt_q <= mcnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_SERVE;
      endcase
    end
  end

  assign p_state  = state_q;
  assign p_misses = miss_q;

  logic [XW-1:0] h_q, col_q;
  logic [YW-1:0] v_q, row_q;
  logic          lit_d, lit_q;

  always_ff @(posedge p_clk12) begin
    if (p_rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == X_MAX) begin
      h_q <= '0;
      v_q <= (v_q == Y_MAX) ? '0 : v_q + 1'b1;
    end else begin
      h_q <= h_q + 1'b1;
    end
  end

  assign lit_d = (h_q == bx_q && v_q == by_q) ||
                 (h_q == '0 && in_pad(v_q, pad_q));

  always_ff @(posedge p_clk12) begin
    if (p_rst) begin
      lit_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      lit_q <= lit_d;
      col_q <= h_q;
      row_q <= v_q;
    end
  end

  for (genvar i = 0; i < COLS; i++) begin : g_h
    assign p_hLED[i] =
      (lit_q && col_q == XW'(i)) ? 1'b0 : 1'bz;
  end

  for (genvar j = 0; j < ROWS; j++) begin : g_v
    assign p_vLED[j] =
      (lit_q && row_q == YW'(j)) ? 1'b1 : 1'bz;
  end

endmodule
